apb_controller: RTL and testbench

//  APB-side sequencer of the AHB-to-APB bridge. Takes a decoded, qualified AHB transfer
//  (valid, address, write flag, slave select) from the AHB slave interface. Runs one APB

---
 rtl/apb_controller.sv | 117 +++++++++++
 tb/tb_apb_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/apb_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: one SETUP/ACCESS transfer per qualified
// AHB transfer, stretching the AHB data phase through hready_out. All outputs registered.
module apb_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              hready_out,
  output logic [DATA_W-1:0] hrdata,
  output logic [NSLV-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata
);

  typedef enum logic [2:0] {IDLE, WWAIT, RSETUP, RACCESS, WSETUP, WACCESS} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, paddr_d;
  logic [NSLV-1:0]   sel_q, sel_d, pselx_d;
  logic [DATA_W-1:0] hrdata_d, pwdata_d;
  logic              hready_d, penable_d, pwrite_d;

  // Every output has a next-value term so the registers below hold by default.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    sel_d     = sel_q;
    hready_d  = hready_out;
    hrdata_d  = hrdata;
    pselx_d   = pselx;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    case (state)
      IDLE: begin
        if (valid) begin
          addr_d   = haddr;
          sel_d    = tempselx;
          hready_d = 1'b0;
          if (hwrite) begin
            state_d = WWAIT;
          end else begin
            state_d  = RSETUP;
            paddr_d  = haddr;
            pselx_d  = tempselx;
            pwrite_d = 1'b0;
          end
        end
      end
      // Write data only arrives in the AHB data phase, so SETUP is deferred one cycle.
      WWAIT: begin
        pwdata_d = hwdata;
        paddr_d  = addr_q;
        pselx_d  = sel_q;
        pwrite_d = 1'b1;
        state_d  = WSETUP;
      end
      RSETUP: begin
        penable_d = 1'b1;
        state_d   = RACCESS;
      end
      WSETUP: begin
        penable_d = 1'b1;
        state_d   = WACCESS;
      end
      RACCESS, WACCESS: begin
        if (pready) begin
          pselx_d   = '0;
          penable_d = 1'b0;
          hready_d  = 1'b1;
          state_d   = IDLE;
          if (state == RACCESS) hrdata_d = prdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= IDLE;
      addr_q     <= '0;
      sel_q      <= '0;
      hready_out <= 1'b1;
      hrdata     <= '0;
      pselx      <= '0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      hready_out <= hready_d;
      hrdata     <= hrdata_d;
      pselx      <= pselx_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench for apb_controller: directed and randomized transfers compared each
// cycle against a transaction-level model of the APB-side output timeline.
module tb_apb_controller;

  logic        hclk = 1'b0;
  logic        hreset, valid, hwrite, pready;
  logic [31:0] haddr, hwdata, prdata;
  logic [2:0]  tempselx;
  logic        hready_out, penable, pwrite;
  logic [31:0] hrdata, paddr, pwdata;
  logic [2:0]  pselx;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Values the protocol says persist between transfers.
  logic [31:0] m_hrdata, m_paddr, m_pwdata;
  logic        m_pwrite;

  logic [101:0] obs;
  assign obs = {hready_out, hrdata, pselx, penable, pwrite, paddr, pwdata};

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .tempselx(tempselx), .prdata(prdata), .pready(pready),
    .hready_out(hready_out), .hrdata(hrdata), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
  );

  always #5 hclk = ~hclk;

  function automatic logic [101:0] exp_vec(input logic rdy, input logic [2:0] sel,
                                           input logic pen);
    return {rdy, m_hrdata, sel, pen, m_pwrite, m_paddr, m_pwdata};
  endfunction

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [2:0] rand_sel();
    return 3'(32'd1 << $urandom_range(2, 0));
  endfunction

  task automatic test_reset();
    hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    tempselx = '0; prdata = '0; pready = 1'b0;
    step(); step();
    m_hrdata = '0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    vectors++;
    if (obs !== exp_vec(1'b1, 3'b000, 1'b0)) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs, exp_vec(1'b1, 3'b000, 1'b0));
    end
    hreset = 1'b0;
  endtask

  // Idle cycles with garbage on the address-phase inputs: nothing may move.
  task automatic test_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      valid = 1'b0; hwrite = 1'($urandom); haddr = $urandom; tempselx = 3'($urandom);
      hwdata = $urandom; prdata = $urandom; pready = 1'($urandom);
      step();
      vectors++;
      if (obs !== exp_vec(1'b1, 3'b000, 1'b0)) begin
        errors++; $display("FAIL idle[%0d] got=%h exp=%h", i, obs, exp_vec(1'b1, 3'b000, 1'b0));
      end
    end
  endtask

  // Entered in an IDLE cycle; returns in the IDLE cycle after completion.
  task automatic test_read(input logic [31:0] addr, input logic [2:0] sel,
                           input logic [31:0] data, input int unsigned waits);
    valid = 1'b1; hwrite = 1'b0; haddr = addr; tempselx = sel;
    pready = 1'($urandom); prdata = $urandom;
    step();
    m_paddr = addr; m_pwrite = 1'b0;
    vectors++;
    if (obs !== exp_vec(1'b0, sel, 1'b0)) begin
      errors++; $display("FAIL rd_setup got=%h exp=%h", obs, exp_vec(1'b0, sel, 1'b0));
    end
    valid = 1'($urandom); hwrite = 1'($urandom); haddr = $urandom; tempselx = rand_sel();
    pready = 1'($urandom); prdata = $urandom;
    step();
    for (int unsigned i = 0; i <= waits; i++) begin
      vectors++;
      if (obs !== exp_vec(1'b0, sel, 1'b1)) begin
        errors++; $display("FAIL rd_access[%0d] got=%h exp=%h", i, obs, exp_vec(1'b0, sel, 1'b1));
      end
      pready = (i == waits);
      prdata = (i == waits) ? data : $urandom;
      step();
    end
    m_hrdata = data;
    vectors++;
    if (obs !== exp_vec(1'b1, 3'b000, 1'b0)) begin
      errors++; $display("FAIL rd_done got=%h exp=%h", obs, exp_vec(1'b1, 3'b000, 1'b0));
    end
    valid = 1'b0; pready = 1'b0;
  endtask

  task automatic test_write(input logic [31:0] addr, input logic [2:0] sel,
                            input logic [31:0] data, input int unsigned waits);
    valid = 1'b1; hwrite = 1'b1; haddr = addr; tempselx = sel; hwdata = $urandom;
    pready = 1'($urandom); prdata = $urandom;
    step();
    vectors++;
    if (obs !== exp_vec(1'b0, 3'b000, 1'b0)) begin
      errors++; $display("FAIL wr_wait got=%h exp=%h", obs, exp_vec(1'b0, 3'b000, 1'b0));
    end
    valid = 1'($urandom); haddr = $urandom; tempselx = rand_sel(); hwdata = data;
    step();
    m_paddr = addr; m_pwdata = data; m_pwrite = 1'b1;
    vectors++;
    if (obs !== exp_vec(1'b0, sel, 1'b0)) begin
      errors++; $display("FAIL wr_setup got=%h exp=%h", obs, exp_vec(1'b0, sel, 1'b0));
    end
    hwdata = $urandom; pready = 1'($urandom);
    step();
    for (int unsigned i = 0; i <= waits; i++) begin
      vectors++;
      if (obs !== exp_vec(1'b0, sel, 1'b1)) begin
        errors++; $display("FAIL wr_access[%0d] got=%h exp=%h", i, obs, exp_vec(1'b0, sel, 1'b1));
      end
      pready = (i == waits); prdata = $urandom;
      step();
    end
    vectors++;
    if (obs !== exp_vec(1'b1, 3'b000, 1'b0)) begin
      errors++; $display("FAIL wr_done got=%h exp=%h", obs, exp_vec(1'b1, 3'b000, 1'b0));
    end
    valid = 1'b0; pready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'hA000_0040; tempselx = 3'b100; pready = 1'b0;
    step();
    valid = 1'b0; hwdata = 32'hCAFE_F00D;
    step();
    step();
    m_paddr = 32'hA000_0040; m_pwdata = 32'hCAFE_F00D; m_pwrite = 1'b1;
    vectors++;
    if (obs !== exp_vec(1'b0, 3'b100, 1'b1)) begin
      errors++; $display("FAIL rst_pre_access got=%h exp=%h", obs, exp_vec(1'b0, 3'b100, 1'b1));
    end
    hreset = 1'b1;
    step();
    m_hrdata = '0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    vectors++;
    if (obs !== exp_vec(1'b1, 3'b000, 1'b0)) begin
      errors++; $display("FAIL rst_mid_access got=%h exp=%h", obs, exp_vec(1'b1, 3'b000, 1'b0));
    end
    hreset = 1'b0;
    test_read(32'h8000_0020, 3'b001, 32'h0BAD_F00D, 1);
  endtask

  task automatic test_back_to_back();
    test_write(32'h8800_0000, 3'b100, 32'h5555_AAAA, 0);
    test_read(32'h8800_0000, 3'b100, 32'h7777_1111, 0);
    test_write(32'h8800_0008, 3'b010, 32'h0000_FFFF, 2);
    test_write(32'h8800_000C, 3'b001, 32'hFFFF_0000, 0);
  endtask

  task automatic test_random(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      if ($urandom_range(1, 0) == 1)
        test_write($urandom, rand_sel(), $urandom, $urandom_range(4, 0));
      else
        test_read($urandom, rand_sel(), $urandom, $urandom_range(4, 0));
      test_idle($urandom_range(2, 0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle(10);
    test_read(32'h8000_0010, 3'b001, 32'hDEAD_BEEF, 0);
    test_idle(1);
    test_write(32'h8400_0004, 3'b010, 32'h1234_5678, 0);
    test_idle(2);
    test_read(32'h8000_0014, 3'b100, 32'h1357_9BDF, 3);
    test_back_to_back();
    test_idle(1);
    test_reset_mid_access();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
